// File: rtl/counter_pkg.sv
// counter_pkg: mode encoding shared by the LED mode counter and its bench-facing users
package counter_pkg;
  typedef enum logic [1:0] {
    MODE_UP      = 2'd0,
    MODE_DOWN    = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_ONESHOT = 2'd3
  } modeT;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: emits one step tick every PRESCALE enabled cycles
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic ipClk,
  input  logic ipReset,
  input  logic ipEnable,
  input  logic ipClear,
  output logic opTick
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] lastPhase = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] onePhase = PW'(1);
  if (PRESCALE < 1) begin : gBadPrescale
    $error("tick_prescaler: PRESCALE must be >= 1");
  end
  logic [PW-1:0] phase;
  assign opTick = ipEnable && phase == lastPhase;
  // phase advances only while enabled and restarts on tick, clear or reset
  always_ff @(posedge ipClk) begin
    if (ipReset || ipClear) phase <= '0;
    else if (ipEnable) phase <= opTick ? '0 : phase + onePhase;
  end
endmodule

// File: rtl/led_mode_counter.sv
// led_mode_counter: prescaled up/down/bounce/one-shot counter driving board LEDs
module led_mode_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 31,
  parameter longint unsigned MAX = (64'd1 << WIDTH) - 64'd1,
  parameter int PRESCALE = 1,
  parameter int LED_WIDTH = 8
) (
  input  logic                 ipClk,
  input  logic                 ipReset,
  input  logic                 ipEnable,
  input  logic [1:0]           ipMode,
  input  logic                 ipLoad,
  input  logic [WIDTH-1:0]     ipLoadValue,
  output logic [WIDTH-1:0]     opCount,
  output logic [LED_WIDTH-1:0] opLED,
  output logic                 opWrap,
  output logic                 opDone
);
  if (MAX < 64'd1 || MAX > (64'd1 << WIDTH) - 64'd1) begin : gBadMax
    $error("led_mode_counter: MAX must be in 1..2**WIDTH-1");
  end
  if (LED_WIDTH < 1 || LED_WIDTH > WIDTH) begin : gBadLed
    $error("led_mode_counter: LED_WIDTH must be in 1..WIDTH");
  end
  localparam logic [WIDTH-1:0] maxVal = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] one = WIDTH'(1);
  modeT mode;
  logic tick, dirDown, atMax, atZero;
  logic [WIDTH-1:0] loadClamp, countNext;
  logic dirNext, wrapNext, doneNext;
  assign mode = modeT'(ipMode);
  assign atMax = opCount == maxVal;
  assign atZero = opCount == '0;
  assign loadClamp = ipLoadValue > maxVal ? maxVal : ipLoadValue;
  assign opLED = opCount[WIDTH-1 -: LED_WIDTH];
  tick_prescaler #(.PRESCALE(PRESCALE)) uPrescaler (
    .ipClk   (ipClk),
    .ipReset (ipReset),
    .ipEnable(ipEnable),
    .ipClear (ipLoad),
    .opTick  (tick)
  );
  // next count, direction and flags; load beats a coincident tick
  always_comb begin
    countNext = opCount;
    dirNext = dirDown && mode == MODE_BOUNCE;
    wrapNext = 1'b0;
    doneNext = opDone && mode == MODE_ONESHOT;
    if (ipLoad) begin
      countNext = loadClamp;
      dirNext = 1'b0;
      doneNext = mode == MODE_ONESHOT && loadClamp == maxVal;
    end else if (tick) begin
      case (mode)
        MODE_UP: begin
          countNext = atMax ? '0 : opCount + one;
          wrapNext = atMax;
        end
        MODE_DOWN: begin
          countNext = atZero ? maxVal : opCount - one;
          wrapNext = atZero;
        end
        MODE_BOUNCE: begin
          countNext = dirDown ? (atZero ? one : opCount - one) : (atMax ? maxVal - one : opCount + one);
          dirNext = dirDown ? !atZero : atMax;
          wrapNext = dirDown ? atZero : atMax;
        end
        default: begin
          countNext = atMax ? opCount : opCount + one;
          wrapNext = !atMax && opCount + one == maxVal;
          doneNext = doneNext || wrapNext;
        end
      endcase
    end
  end
  // state register with reset taking priority over load
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      opCount <= '0;
      dirDown <= 1'b0;
      opWrap <= 1'b0;
      opDone <= 1'b0;
    end else begin
      opCount <= countNext;
      dirDown <= dirNext;
      opWrap <= wrapNext;
      opDone <= doneNext;
    end
  end
endmodule

// File: tb/tb_led_mode_counter.sv
// tb_led_mode_counter: scenario tasks plus randomized run against a behavioural model
module tb_led_mode_counter;
  localparam int W = 4, MAXV = 9, PRE = 3, LW = 2;
  logic ipClk = 1'b0, ipReset = 1'b1, ipEnable = 1'b0, ipLoad = 1'b0;
  logic [1:0] ipMode = 2'd0;
  logic [W-1:0] ipLoadValue = '0;
  logic [W-1:0] opCount;
  logic [LW-1:0] opLED;
  logic opWrap, opDone;
  logic dReset = 1'b1, dLoad = 1'b0, dWrap, dDone;
  logic [30:0] dLoadValue = '0, dCount;
  logic [7:0] dLED;
  int nCmp = 0, nErr = 0;
  int mCount = 0, mDir = 0, mPre = 0, mWrap = 0, mDone = 0;

  always #5 ipClk = ~ipClk;

  led_mode_counter #(.WIDTH(W), .MAX(9), .PRESCALE(PRE), .LED_WIDTH(LW)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipEnable(ipEnable), .ipMode(ipMode),
    .ipLoad(ipLoad), .ipLoadValue(ipLoadValue),
    .opCount(opCount), .opLED(opLED), .opWrap(opWrap), .opDone(opDone)
  );

  led_mode_counter dutDef (
    .ipClk(ipClk), .ipReset(dReset), .ipEnable(1'b1), .ipMode(2'd0),
    .ipLoad(dLoad), .ipLoadValue(dLoadValue),
    .opCount(dCount), .opLED(dLED), .opWrap(dWrap), .opDone(dDone)
  );

  // model advances by the documented rules, then one clock passes
  task automatic step();
    int lv = int'(ipLoadValue);
    bit t = ipEnable && mPre == PRE - 1;
    if (ipReset) begin
      mCount = 0; mDir = 0; mPre = 0; mWrap = 0; mDone = 0;
    end else if (ipLoad) begin
      mCount = lv > MAXV ? MAXV : lv;
      mDir = 0; mPre = 0; mWrap = 0;
      mDone = (ipMode == 2'd3 && mCount == MAXV) ? 1 : 0;
    end else begin
      mWrap = 0;
      if (ipMode != 2'd3) mDone = 0;
      if (ipEnable) mPre = (mPre + 1) % PRE;
      if (t) begin
        case (ipMode)
          2'd0: begin mWrap = mCount == MAXV; mCount = (mCount + 1) % (MAXV + 1); end
          2'd1: begin mWrap = mCount == 0; mCount = mCount == 0 ? MAXV : mCount - 1; end
          2'd2: begin
            int nx = mDir ? mCount - 1 : mCount + 1;
            if (nx < 0 || nx > MAXV) begin
              mWrap = 1; mDir = 1 - mDir;
              nx = mDir ? MAXV - 1 : 1;
            end
            mCount = nx;
          end
          default: if (mCount < MAXV) begin
            mCount++;
            if (mCount == MAXV) begin mWrap = 1; mDone = 1; end
          end
        endcase
      end
      if (ipMode != 2'd2) mDir = 0;
    end
    @(posedge ipClk); #1;
  endtask

  task automatic test_reset();
    ipReset = 1'b1; ipLoad = 1'b0; ipEnable = 1'b1;
    step(); step();
    nCmp++; if (opCount !== 4'd0 || opWrap !== 1'b0 || opDone !== 1'b0 || opLED !== 2'd0) begin nErr++; $display("FAIL reset: count=%0d wrap=%b done=%b led=%0d, required 0/0/0/0", opCount, opWrap, opDone, opLED); end
  endtask

  task automatic test_up();
    int wraps = 0;
    ipReset = 1'b1; step(); ipReset = 1'b0; ipMode = 2'd0; ipEnable = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step(); wraps += int'(opWrap);
      nCmp++; if (opCount !== 4'(mCount) || opWrap !== (mWrap != 0) || opLED !== 2'(mCount >> 2)) begin nErr++; $display("FAIL up_cycle%0d: count=%0d wrap=%b led=%0d, required %0d/%0d/%0d", i, opCount, opWrap, opLED, mCount, mWrap, mCount >> 2); end
      if (i == 3) begin nCmp++; if (opCount !== 4'd1) begin nErr++; $display("FAIL up_first_step: count=%0d, required 1", opCount); end end
      if (i == 27) begin nCmp++; if (opCount !== 4'd9 || opWrap !== 1'b0) begin nErr++; $display("FAIL up_at_max: count=%0d wrap=%b, required 9/0", opCount, opWrap); end end
    end
    nCmp++; if (opCount !== 4'd0 || opWrap !== 1'b1 || wraps != 1) begin nErr++; $display("FAIL up_period: count=%0d wrap=%b pulses=%0d, required 0/1/1", opCount, opWrap, wraps); end
    step();
    nCmp++; if (opWrap !== 1'b0) begin nErr++; $display("FAIL up_wrap_width: wrap=%b, required 0", opWrap); end
  endtask

  task automatic test_down();
    ipReset = 1'b1; step(); ipReset = 1'b0; ipMode = 2'd1; ipEnable = 1'b1;
    step(); step(); step();
    nCmp++; if (opCount !== 4'd9 || opWrap !== 1'b1) begin nErr++; $display("FAIL down_first: count=%0d wrap=%b, required 9/1", opCount, opWrap); end
    step(); step(); step();
    nCmp++; if (opCount !== 4'd8 || opWrap !== 1'b0) begin nErr++; $display("FAIL down_second: count=%0d wrap=%b, required 8/0", opCount, opWrap); end
    step(); step(); step();
    nCmp++; if (opCount !== 4'd7) begin nErr++; $display("FAIL down_third: count=%0d, required 7", opCount); end
  endtask

  task automatic test_bounce();
    int wraps = 0;
    ipReset = 1'b1; step(); ipReset = 1'b0; ipMode = 2'd2; ipEnable = 1'b1;
    for (int i = 1; i <= 39; i++) begin
      step(); wraps += int'(opWrap);
      nCmp++; if (opCount !== 4'(mCount) || opWrap !== (mWrap != 0)) begin nErr++; $display("FAIL bounce_cycle%0d: count=%0d wrap=%b, required %0d/%0d", i, opCount, opWrap, mCount, mWrap); end
    end
    nCmp++; if (opCount !== 4'd5 || wraps != 1) begin nErr++; $display("FAIL bounce_descend: count=%0d pulses=%0d, required 5/1", opCount, wraps); end
    ipMode = 2'd0; step(); step(); step();
    nCmp++; if (opCount !== 4'd6) begin nErr++; $display("FAIL bounce_to_up: count=%0d, required 6", opCount); end
    ipMode = 2'd2; wraps = 0;
    for (int i = 1; i <= 39; i++) begin
      step(); wraps += int'(opWrap);
      nCmp++; if (opCount !== 4'(mCount) || opWrap !== (mWrap != 0)) begin nErr++; $display("FAIL bounce2_cycle%0d: count=%0d wrap=%b, required %0d/%0d", i, opCount, opWrap, mCount, mWrap); end
    end
    nCmp++; if (opCount !== 4'd1 || wraps != 2) begin nErr++; $display("FAIL bounce_turns: count=%0d pulses=%0d, required 1/2", opCount, wraps); end
  endtask

  task automatic test_oneshot();
    int wraps = 0;
    ipReset = 1'b1; step(); ipReset = 1'b0; ipMode = 2'd3; ipEnable = 1'b1;
    for (int i = 1; i <= 27; i++) begin step(); wraps += int'(opWrap); end
    nCmp++; if (opCount !== 4'd9 || opDone !== 1'b1 || opWrap !== 1'b1 || wraps != 1) begin nErr++; $display("FAIL oneshot_reach: count=%0d done=%b wrap=%b pulses=%0d, required 9/1/1/1", opCount, opDone, opWrap, wraps); end
    wraps = 0;
    for (int i = 1; i <= 20; i++) begin step(); wraps += int'(opWrap); end
    nCmp++; if (opCount !== 4'd9 || opDone !== 1'b1 || wraps != 0) begin nErr++; $display("FAIL oneshot_hold: count=%0d done=%b pulses=%0d, required 9/1/0", opCount, opDone, wraps); end
    ipLoad = 1'b1; ipLoadValue = 4'd0; step(); ipLoad = 1'b0;
    nCmp++; if (opCount !== 4'd0 || opDone !== 1'b0) begin nErr++; $display("FAIL oneshot_reload: count=%0d done=%b, required 0/0", opCount, opDone); end
    step(); step(); step();
    nCmp++; if (opCount !== 4'd1) begin nErr++; $display("FAIL oneshot_restart: count=%0d, required 1", opCount); end
  endtask

  task automatic test_load_enable();
    ipMode = 2'd0; ipEnable = 1'b1;
    ipLoad = 1'b1; ipLoadValue = 4'd15; step(); ipLoad = 1'b0;
    nCmp++; if (opCount !== 4'd9) begin nErr++; $display("FAIL load_clamp: count=%0d, required 9", opCount); end
    step(); step();
    ipLoad = 1'b1; ipLoadValue = 4'd4; step(); ipLoad = 1'b0;
    nCmp++; if (opCount !== 4'd4 || opWrap !== 1'b0) begin nErr++; $display("FAIL load_vs_tick: count=%0d wrap=%b, required 4/0", opCount, opWrap); end
    step(); ipEnable = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      nCmp++; if (opCount !== 4'd4 || opWrap !== 1'b0) begin nErr++; $display("FAIL freeze%0d: count=%0d wrap=%b, required 4/0", i, opCount, opWrap); end
    end
    ipEnable = 1'b1; step();
    nCmp++; if (opCount !== 4'd4) begin nErr++; $display("FAIL resume_early: count=%0d, required 4", opCount); end
    step();
    nCmp++; if (opCount !== 4'd5 || opCount !== 4'(mCount)) begin nErr++; $display("FAIL resume_step: count=%0d, required 5 (model %0d)", opCount, mCount); end
  endtask

  task automatic test_reset_mid();
    ipMode = 2'd3; ipEnable = 1'b1;
    ipLoad = 1'b1; ipLoadValue = 4'd9; step();
    nCmp++; if (opDone !== 1'b1) begin nErr++; $display("FAIL load_max_done: done=%b, required 1", opDone); end
    ipLoadValue = 4'd5; step();
    nCmp++; if (opCount !== 4'd5 || opDone !== 1'b0) begin nErr++; $display("FAIL load_five: count=%0d done=%b, required 5/0", opCount, opDone); end
    ipReset = 1'b1; ipLoadValue = 4'd7; step(); ipReset = 1'b0; ipLoad = 1'b0;
    nCmp++; if (opCount !== 4'd0 || opDone !== 1'b0 || opWrap !== 1'b0) begin nErr++; $display("FAIL reset_over_load: count=%0d done=%b wrap=%b, required 0/0/0", opCount, opDone, opWrap); end
  endtask

  task automatic test_random();
    ipReset = 1'b1; step(); ipReset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      ipReset = $urandom_range(63) == 0;
      ipLoad = $urandom_range(15) == 0;
      ipLoadValue = 4'($urandom_range(15));
      ipEnable = $urandom_range(3) != 0;
      if ($urandom_range(19) == 0) ipMode = 2'($urandom_range(3));
      step();
      nCmp++; if (opCount !== 4'(mCount) || opWrap !== (mWrap != 0) || opDone !== (mDone != 0) || opLED !== 2'(mCount >> 2)) begin nErr++; $display("FAIL random%0d: count=%0d wrap=%b done=%b led=%0d, required %0d/%0d/%0d/%0d", i, opCount, opWrap, opDone, opLED, mCount, mWrap, mDone, mCount >> 2); end
    end
    ipReset = 1'b0; ipLoad = 1'b0;
  endtask

  task automatic test_default_led();
    logic [30:0] v, e;
    dReset = 1'b1; step(); dReset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      v = 31'($urandom);
      dLoad = 1'b1; dLoadValue = v; step(); dLoad = 1'b0;
      nCmp++; if (dCount !== v || dLED !== v[30:23]) begin nErr++; $display("FAIL default_load%0d: count=%h led=%h, required %h/%h", k, dCount, dLED, v, v[30:23]); end
      for (int i = 0; i < 5; i++) step();
      e = v + 31'd5;
      nCmp++; if (dCount !== e || dLED !== e[30:23]) begin nErr++; $display("FAIL default_run%0d: count=%h led=%h, required %h/%h", k, dCount, dLED, e, e[30:23]); end
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_down();
    test_bounce();
    test_oneshot();
    test_load_enable();
    test_reset_mid();
    test_random();
    test_default_led();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule

// File: doc/led_mode_counter.md
Name: led_mode_counter

Overview:
- Parametrised successor to the free-running LED counter.
- Provides a prescaled counter with selectable up, down, bounce and one-shot modes, a programmable terminal value, synchronous load and enable.
- Outputs a terminal-event pulse and a done flag. The top bits of the count drive the board LEDs.
- With default parameters, MODE_UP and ipEnable=1, it reproduces the legacy behaviour: opLED = count[30:23].

Parameters:
- WIDTH, 31: count register width.
- MAX, 2**WIDTH-1: terminal count value. Must satisfy 1 <= MAX <= 2**WIDTH-1; violations are rejected at elaboration.
- PRESCALE, 1: enabled clock cycles per count step. Must be >= 1.
- LED_WIDTH, 8: number of LED outputs. Must be <= WIDTH.

Ports:
- ipClk  input  1  system clock, all logic on rising edge.
- ipReset  input  1  synchronous, active-high reset.
- ipEnable  input  1  advances the prescaler when high; prescaler and count freeze when low.
- ipMode  input  2  0=UP, 1=DOWN, 2=BOUNCE, 3=ONESHOT.
- ipLoad  input  1  synchronous load strobe.
- ipLoadValue  input  WIDTH  value to load.
- opCount  output  WIDTH  current count.
- opLED  output  LED_WIDTH  opCount[WIDTH-1 -: LED_WIDTH].
- opWrap  output  1  one-cycle terminal-event pulse.
- opDone  output  1  ONESHOT complete (level).

Behaviour:
- Interface: one clock, ipClk; synchronous active-high reset, ipReset. All outputs are registered.
- Reset:
  - opCount=0, prescaler=0, direction=up, opWrap=0, opDone=0.
  - ipReset has priority over everything, including ipLoad.
- Prescaler:
  - Counts 0..PRESCALE-1 on cycles where ipEnable=1. The step tick is the enabled cycle where prescaler==PRESCALE-1; the prescaler returns to 0 on that cycle.
  - PRESCALE=1 gives a tick on every enabled cycle.
  - ipEnable=0 holds the prescaler and count and forces opWrap=0.
- Load:
  - When ipLoad=1 and not in reset: opCount <= min(ipLoadValue, MAX), prescaler <= 0, direction <= up, opWrap <= 0, opDone <= (mode==ONESHOT && loaded value==MAX).
  - Load is independent of ipEnable and wins over a coincident tick.
- Step, on tick with no load:
  - UP: count<MAX gives +1. count==MAX gives 0 and opWrap=1.
  - DOWN: count>0 gives -1. count==0 gives MAX and opWrap=1.
  - BOUNCE, direction up: count<MAX gives +1. At MAX: count <= MAX-1, direction <= down, opWrap=1.
  - BOUNCE, direction down: count>0 gives -1. At 0: count <= 1, direction <= up, opWrap=1.
  - ONESHOT: count<MAX gives +1. On the step that reaches MAX: opWrap=1 and opDone=1. Further ticks hold MAX with opWrap=0.
- opWrap timing: high for exactly the one cycle in which the new count value is first visible. It is 0 on every other cycle.
- opDone:
  - Cleared by reset or by a load of a value < MAX.
  - Cleared on any cycle where ipMode != ONESHOT.
- Mode change mid-run:
  - Takes effect on the next tick; no state is cleared.
  - Direction is forced to up while ipMode != BOUNCE.
- Counter arithmetic is WIDTH bits; wrap is only via the rules above, never via natural overflow (unless MAX=2**WIDTH-1, where the results coincide).
- Count latency: after reset/load, the first count change occurs PRESCALE enabled cycles later.

Decomposition:
- Package counter_pkg holds:
  - mode constants MODE_UP, MODE_DOWN, MODE_BOUNCE, MODE_ONESHOT (2-bit);
  - a typedef for the mode field.
- Sub-module tick_prescaler: parameter PRESCALE; ports ipClk, ipReset, ipEnable, ipClear, opTick. ipClear is driven by ipLoad. opTick is combinational from its internal register.
- Top-level led_mode_counter contains the count/direction/flag logic.

Test Plan (WIDTH=4, MAX=9, PRESCALE=3, LED_WIDTH=2 unless stated):
1. Reset, then UP with ipEnable=1:
   - Count changes 0->1 after 3 cycles and steps every 3 cycles.
   - 9->0 with opWrap high for exactly 1 cycle.
   - Full period is 30 cycles.
   - opLED=count[3:2].
2. DOWN from reset: first tick gives count 9 with opWrap=1, then 8, 7 … every 3 cycles.
3. BOUNCE:
   - Sequence 0..9,8..0,1.
   - opWrap on the 9->8 and 0->1 steps only.
   - Switching to UP while descending at 5 gives next step 6.
4. ONESHOT:
   - Reaches 9 with one opWrap pulse; opDone=1 thereafter.
   - 20 more cycles hold at 9 with no pulse.
   - ipLoad with value 0 clears opDone and restarts.
5. Load and enable:
   - ipLoadValue=15 loads 9 (clamped).
   - Load coincident with a tick at count 9 in UP gives count=load value and opWrap=0.
   - ipEnable=0 for 10 cycles freezes count and prescaler; resuming completes the remaining prescale cycles.
6. Reset mid-operation: count=5 with ipLoad=1 and ipReset=1 in the same cycle gives count=0, opDone=0, opWrap=0 next cycle. Defaults (WIDTH=31, UP) give opLED=count[30:23].
